wb_mul_initiator: RTL and testbench
===================================

# wb_mul_initiator

Wishbone classic initiator that drives the multiplier's Wishbone responder port. It accepts an 8-bit operand pair on a valid/ready command interface, writes the operands to the multiplier, reads back the product, and returns it on a valid/ready response interface. A per-phase timeout flags a transfer that is never acknowledged. It sits between the LA/test-sequencing logic and the Wishbone bus that feeds the multiplier.

## Interface
- ADDR_OPND, 32'h3000_0000, byte address of the operand register
- ADDR_PROD, 32'h3000_0004, byte address of the product register
- TIMEOUT, 16, cycles allowed per bus phase before abort (≥2)
- wb_clk_i  in  1  clock; the only clock
- wb_rst_i  in  1  reset, synchronous, active-high
- cmd_valid_i  in  1  operand pair valid
- cmd_ready_o  out  1  block can accept a command
- cmd_a_i  in  8  operand a
- cmd_b_i  in  8  operand b
- rsp_valid_o  out  1  response valid
- rsp_ready_i  in  1  consumer accepts response
- rsp_p_o  out  16  product (zero on error)
- rsp_err_o  out  1  transfer aborted (timeout or bus error)
- wbm_cyc_o, wbm_stb_o, wbm_we_o  out  1 each  Wishbone cycle, strobe, write enable
- wbm_sel_o  out  4  byte selects
- wbm_adr_o  out  32  address
- wbm_dat_o  out  32  write data
- wbm_dat_i  in  32  read data
- wbm_ack_i  in  1  acknowledge
- wbm_err_i  in  1  bus error

## Operation
- Four states: IDLE, WR, RD, RSP.
- IDLE: cmd_ready_o=1. On cmd_valid_i && cmd_ready_o, latch a and b and go to WR.
- WR: cyc=stb=we=1, adr=ADDR_OPND, dat_o={16'h0, b, a}, sel=4'b0011.
  - On ack: go to RD.
  - On err or timeout: go to RSP with err=1.
- RD: cyc=stb=1, we=0, adr=ADDR_PROD, sel=4'b1111, dat_o=0.
  - On ack: capture rsp_p_o=wbm_dat_i[15:0], err=0, go to RSP.
  - On err or timeout: go to RSP with err=1 and p=0.
- RSP: rsp_valid_o=1. Response fields stay stable until rsp_ready_i, then go to IDLE.
- Width rule: the upper 16 bits of wbm_dat_i are ignored. The product is the multiplier's value and is not recomputed locally.
- Timeout: a phase counter clears on every WR or RD entry and increments each cycle in the phase with no ack/err. In the phase cycle where the count equals TIMEOUT-1 with no ack and no err, abort.
- Simultaneous events:
  - ack and timeout in the same cycle: ack wins.
  - ack and err in the same cycle: err wins.
- ack/err seen in IDLE or RSP is ignored.
- Reset values: cmd_ready_o=0 during reset, then 1 from the first cycle after reset; all other outputs 0; state IDLE.
- Reset mid-transfer: cyc/stb drop at the next edge, the transfer is abandoned and no response is issued.

## Timing
- All outputs are registered from state or latched data. No combinational path from wbm_ack_i to any output.
- cyc stays high continuously from WR entry through the end of RD; it drops on RSP entry.
- Minimum latency with zero-wait responder (cycle 0 = command handshake):
  - cycle 1: WR asserted, ack
  - cycle 2: RD asserted, ack
  - cycle 3: rsp_valid_o
- Throughput: one command per 4 cycles when rsp_ready_i=1. The next command is accepted in the cycle after the response handshake.
- Abort at the latest: rsp_valid_o rises TIMEOUT cycles after phase entry.

## Structure
- Package wb_mul_pkg:
  - state enum (IDLE/WR/RD/RSP)
  - default ADDR_OPND/ADDR_PROD
  - SEL_OPND=4'b0011, SEL_WORD=4'b1111
- One sub-module: wb_phase_timer (clear, count enable, expire output, parameterised by TIMEOUT), reused by future initiators.

## Test plan
- Zero-wait responder, a=8'd13, b=8'd11 → one write {16'h0,8'd11,8'd13} to ADDR_OPND with sel 0011, one read of ADDR_PROD; rsp_p_o=16'd143, err=0; rsp_valid_o at cycle 3.
- Responder inserts 3 wait states per phase, a=8'hFF, b=8'hFF → p=16'hFE01; cyc held high throughout; stb/adr/dat stable while waiting.
- Responder never acks WR (TIMEOUT=16) → abort after 16 WR cycles; rsp_err_o=1, rsp_p_o=0; no read issued.
- wbm_err_i in RD; and separately ack together with err → err=1, p=0. Ack arriving exactly on the timeout cycle → normal completion.
- rsp_ready_i held low 5 cycles → rsp_valid_o, p and err stable, cmd_ready_o=0; a second cmd_valid_i is not accepted until after the response handshake.
- wb_rst_i asserted during RD wait → next cycle cyc=stb=0, rsp_valid_o=0; after reset no response appears and a new command completes normally.

Source files
------------

// File: rtl/wb_mul_pkg.sv
// wb_mul_pkg
// Shared types and constants for Wishbone initiators that talk to the
// multiplier responder: FSM state encoding, default register addresses
// and byte-select patterns.
package wb_mul_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WR   = 2'd1,
      RD   = 2'd2,
      RSP  = 2'd3
   } state_t;

   localparam logic [31:0] ADDR_OPND_DEF = 32'h3000_0000;
   localparam logic [31:0] ADDR_PROD_DEF = 32'h3000_0004;

   localparam logic [3:0]  SEL_OPND = 4'b0011;   // operands occupy the low half-word
   localparam logic [3:0]  SEL_WORD = 4'b1111;

endpackage

// File: rtl/wb_phase_timer.sv
// wb_phase_timer
// Counts cycles spent in one bus phase and flags expiry after TIMEOUT cycles.
// Ports:
//   clk    - clock
//   rst    - synchronous active-high reset
//   clr    - restart the count (asserted on phase entry)
//   en     - count this cycle (phase active, no ack/err)
//   expire - count has reached TIMEOUT-1: this is the last allowed cycle
module wb_phase_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clr,
   input  logic en,
   output logic expire
);

   localparam int CW = $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   assign expire = (cnt == CW'(TIMEOUT - 1));

   // Saturates at TIMEOUT-1 so a lingering enable can never wrap back to
   // a "fresh" count before the owner reacts to expire.
   always_ff @(posedge clk) begin
      if (rst || clr)
         cnt <= '0;
      else if (en && !expire)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/wb_mul_initiator.sv
// wb_mul_initiator
// Wishbone classic initiator for the multiplier. A command (a, b) is
// written to the operand register, the product register is read back and
// returned on the response channel. Each bus phase is bounded by a timeout.
// Ports:
//   wb_clk_i, wb_rst_i            - clock, synchronous active-high reset
//   cmd_valid_i/cmd_ready_o       - command handshake, operands cmd_a_i/cmd_b_i
//   rsp_valid_o/rsp_ready_i       - response handshake, rsp_p_o / rsp_err_o
//   wbm_*                         - Wishbone classic initiator port
module wb_mul_initiator
   import wb_mul_pkg::*;
#(
   parameter logic [31:0] ADDR_OPND = ADDR_OPND_DEF,
   parameter logic [31:0] ADDR_PROD = ADDR_PROD_DEF,
   parameter int          TIMEOUT   = 16
) (
   input  logic        wb_clk_i,
   input  logic        wb_rst_i,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [7:0]  cmd_a_i,
   input  logic [7:0]  cmd_b_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [15:0] rsp_p_o,
   output logic        rsp_err_o,
   output logic        wbm_cyc_o,
   output logic        wbm_stb_o,
   output logic        wbm_we_o,
   output logic [3:0]  wbm_sel_o,
   output logic [31:0] wbm_adr_o,
   output logic [31:0] wbm_dat_o,
   input  logic [31:0] wbm_dat_i,
   input  logic        wbm_ack_i,
   input  logic        wbm_err_i
);

   state_t      state, state_n;
   logic [7:0]  a_q, a_n, b_q, b_n;
   logic [15:0] p_q, p_n;
   logic        err_q, err_n;
   logic        rdy_en;        // low while in reset, keeps cmd_ready_o off
   logic        tmr_clr, tmr_en, tmr_exp;

   // The multiplier only drives the low half-word.
   logic unused_hi;
   assign unused_hi = ^wbm_dat_i[31:16];

   wb_phase_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk    (wb_clk_i),
      .rst    (wb_rst_i),
      .clr    (tmr_clr),
      .en     (tmr_en),
      .expire (tmr_exp)
   );

   // Restart the timer whenever a bus phase is entered.
   assign tmr_clr = (state_n != state) && (state_n == WR || state_n == RD);

   always_ff @(posedge wb_clk_i) begin
      if (wb_rst_i) begin
         state  <= IDLE;
         a_q    <= '0;
         b_q    <= '0;
         p_q    <= '0;
         err_q  <= 1'b0;
         rdy_en <= 1'b0;
      end else begin
         state  <= state_n;
         a_q    <= a_n;
         b_q    <= b_n;
         p_q    <= p_n;
         err_q  <= err_n;
         rdy_en <= 1'b1;
      end
   end

   // Outputs decode only the state register and latched data, so there is
   // no path from wbm_ack_i/wbm_err_i to any output.
   always_comb begin
      state_n     = state;
      a_n         = a_q;
      b_n         = b_q;
      p_n         = p_q;
      err_n       = err_q;
      tmr_en      = 1'b0;
      cmd_ready_o = 1'b0;
      rsp_valid_o = 1'b0;
      wbm_cyc_o   = 1'b0;
      wbm_stb_o   = 1'b0;
      wbm_we_o    = 1'b0;
      wbm_sel_o   = '0;
      wbm_adr_o   = '0;
      wbm_dat_o   = '0;

      case (state)
         IDLE: begin
            cmd_ready_o = rdy_en;
            if (cmd_valid_i && rdy_en) begin
               a_n     = cmd_a_i;
               b_n     = cmd_b_i;
               state_n = WR;
            end
         end
         WR: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_we_o  = 1'b1;
            wbm_sel_o = SEL_OPND;
            wbm_adr_o = ADDR_OPND;
            wbm_dat_o = {16'h0, b_q, a_q};
            tmr_en    = !wbm_ack_i && !wbm_err_i;
            // err beats ack; ack beats timeout
            if (wbm_err_i || (!wbm_ack_i && tmr_exp)) begin
               p_n     = '0;
               err_n   = 1'b1;
               state_n = RSP;
            end else if (wbm_ack_i) begin
               state_n = RD;
            end
         end
         RD: begin
            wbm_cyc_o = 1'b1;
            wbm_stb_o = 1'b1;
            wbm_sel_o = SEL_WORD;
            wbm_adr_o = ADDR_PROD;
            tmr_en    = !wbm_ack_i && !wbm_err_i;
            if (wbm_err_i || (!wbm_ack_i && tmr_exp)) begin
               p_n     = '0;
               err_n   = 1'b1;
               state_n = RSP;
            end else if (wbm_ack_i) begin
               p_n     = wbm_dat_i[15:0];
               err_n   = 1'b0;
               state_n = RSP;
            end
         end
         RSP: begin
            rsp_valid_o = 1'b1;
            if (rsp_ready_i)
               state_n = IDLE;
         end
         default: state_n = IDLE;
      endcase
   end

   assign rsp_p_o   = p_q;
   assign rsp_err_o = err_q;

endmodule

// File: tb/tb_wb_mul_initiator.sv
// tb_wb_mul_initiator
// Directed bench: a small Wishbone multiplier responder with programmable
// wait states / error injection, and one task per scenario.
module tb_wb_mul_initiator;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [7:0]  cmd_a = '0, cmd_b = '0;
   logic        rsp_valid;
   logic        rsp_ready = 1'b1;
   logic [15:0] rsp_p;
   logic        rsp_err;
   logic        cyc, stb, we;
   logic [3:0]  sel;
   logic [31:0] adr, dat_o, dat_i;
   logic        ack, err;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   wb_mul_initiator dut (
      .wb_clk_i    (clk),
      .wb_rst_i    (rst),
      .cmd_valid_i (cmd_valid),
      .cmd_ready_o (cmd_ready),
      .cmd_a_i     (cmd_a),
      .cmd_b_i     (cmd_b),
      .rsp_valid_o (rsp_valid),
      .rsp_ready_i (rsp_ready),
      .rsp_p_o     (rsp_p),
      .rsp_err_o   (rsp_err),
      .wbm_cyc_o   (cyc),
      .wbm_stb_o   (stb),
      .wbm_we_o    (we),
      .wbm_sel_o   (sel),
      .wbm_adr_o   (adr),
      .wbm_dat_o   (dat_o),
      .wbm_dat_i   (dat_i),
      .wbm_ack_i   (ack),
      .wbm_err_i   (err)
   );

   // ---------------- responder model ----------------
   int  wr_wait = 0, rd_wait = 0;
   bit  wr_never = 0, rd_err = 0, rd_ackerr = 0;
   int  wcnt = 0;
   logic [15:0] mul_q = '0;
   logic hit;

   assign hit   = cyc && stb && (we ? (!wr_never && wcnt == wr_wait) : (wcnt == rd_wait));
   assign ack   = hit && !(!we && rd_err);
   assign err   = hit && !we && (rd_err || rd_ackerr);
   assign dat_i = {16'hDEAD, mul_q};

   int          wr_ok = 0, rd_ok = 0, rd_stb_n = 0, cyc_rise = 0, stab_bad = 0;
   logic [31:0] last_wadr = '0, last_wdat = '0, last_radr = '0;
   logic [3:0]  last_wsel = '0, last_rsel = '0;
   logic        cyc_d = 1'b0, hold = 1'b0, h_we = 1'b0;
   logic [31:0] h_adr = '0, h_dat = '0;
   logic [3:0]  h_sel = '0;

   always @(posedge clk) begin
      if (rst || !(cyc && stb) || ack || err) wcnt <= 0;
      else                                    wcnt <= wcnt + 1;
      if (cyc && stb && we && ack && !err) begin
         mul_q     <= {8'h0, dat_o[7:0]} * {8'h0, dat_o[15:8]};
         wr_ok     <= wr_ok + 1;
         last_wadr <= adr;
         last_wdat <= dat_o;
         last_wsel <= sel;
      end
      if (cyc && stb && !we && ack && !err) begin
         rd_ok     <= rd_ok + 1;
         last_radr <= adr;
         last_rsel <= sel;
      end
      if (cyc && stb && !we) rd_stb_n <= rd_stb_n + 1;
      cyc_d <= cyc;
      if (cyc && !cyc_d) cyc_rise <= cyc_rise + 1;
      // request must hold steady across wait states
      if (hold && cyc && stb && (adr != h_adr || dat_o != h_dat || sel != h_sel || we != h_we))
         stab_bad <= stab_bad + 1;
      hold  <= cyc && stb && !ack && !err && !rst;
      h_adr <= adr;
      h_dat <= dat_o;
      h_sel <= sel;
      h_we  <= we;
   end

   // ---------------- helpers ----------------
   task automatic cycle();
      @(posedge clk);
      #1;
   endtask

   // Issues one command and returns at the first cycle rsp_valid is seen
   // (cycle 0 = command handshake). Leaves the response pending.
   task automatic run_cmd(input logic [7:0] a, input logic [7:0] b,
                          output int lat, output logic [15:0] p,
                          output logic e, output bit to);
      int n;
      n = 0;
      cmd_valid = 1'b1;
      cmd_a     = a;
      cmd_b     = b;
      while (!cmd_ready && n < 20) begin cycle(); n++; end
      cycle();
      cmd_valid = 1'b0;
      lat = 1;
      while (!rsp_valid && lat < 100) begin cycle(); lat++; end
      p  = rsp_p;
      e  = rsp_err;
      to = !rsp_valid;
   endtask

   // ---------------- scenarios ----------------
   task automatic test_reset();
      rst = 1'b1;
      repeat (3) cycle();
      total++; if (cmd_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b want=0", cmd_ready); end
      total++; if ({cyc, stb, we, rsp_valid, rsp_err} !== 5'b0) begin bad++; $display("FAIL rst_ctl got=%b want=00000", {cyc, stb, we, rsp_valid, rsp_err}); end
      total++; if ({adr, dat_o, sel, rsp_p} !== 84'h0) begin bad++; $display("FAIL rst_data got=%h want=0", {adr, dat_o, sel, rsp_p}); end
      rst = 1'b0;
      cycle();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rst_ready_after got=%b want=1", cmd_ready); end
   endtask

   task automatic test_zero_wait();
      int lat; logic [15:0] p; logic e; bit to; int w0, r0;
      w0 = wr_ok; r0 = rd_ok;
      run_cmd(8'd13, 8'd11, lat, p, e, to);
      total++; if (to) begin bad++; $display("FAIL zw_timeout got=no_rsp want=rsp"); end
      total++; if (lat !== 3) begin bad++; $display("FAIL zw_latency got=%0d want=3", lat); end
      total++; if (p !== 16'd143 || e !== 1'b0) begin bad++; $display("FAIL zw_rsp got=%0d/%b want=143/0", p, e); end
      total++; if (wr_ok - w0 !== 1 || rd_ok - r0 !== 1) begin bad++; $display("FAIL zw_xfers got=%0d/%0d want=1/1", wr_ok - w0, rd_ok - r0); end
      total++; if (last_wdat !== 32'h0000_0B0D) begin bad++; $display("FAIL zw_wdat got=%h want=00000b0d", last_wdat); end
      total++; if (last_wadr !== 32'h3000_0000 || last_wsel !== 4'b0011) begin bad++; $display("FAIL zw_wadr got=%h/%b want=30000000/0011", last_wadr, last_wsel); end
      total++; if (last_radr !== 32'h3000_0004 || last_rsel !== 4'b1111) begin bad++; $display("FAIL zw_radr got=%h/%b want=30000004/1111", last_radr, last_rsel); end
      cycle();
      total++; if (cmd_ready !== 1'b1 || rsp_valid !== 1'b0) begin bad++; $display("FAIL zw_next got=%b/%b want=1/0", cmd_ready, rsp_valid); end
   endtask

   task automatic test_rd_err();
      int lat; logic [15:0] p; logic e; bit to;
      // err in RD after one wait state
      rd_err = 1; rd_wait = 1;
      run_cmd(8'd3, 8'd4, lat, p, e, to);
      total++; if (to || p !== 16'd0 || e !== 1'b1) begin bad++; $display("FAIL rderr_rsp got=%0d/%b want=0/1", p, e); end
      total++; if (lat !== 4) begin bad++; $display("FAIL rderr_latency got=%0d want=4", lat); end
      cycle();
      rd_err = 0;
      // ack on the last allowed cycle completes normally
      rd_wait = 15;
      run_cmd(8'd2, 8'd3, lat, p, e, to);
      total++; if (to || p !== 16'd6 || e !== 1'b0) begin bad++; $display("FAIL ackto_rsp got=%0d/%b want=6/0", p, e); end
      total++; if (lat !== 18) begin bad++; $display("FAIL ackto_latency got=%0d want=18", lat); end
      cycle();
      // ack together with err
      rd_ackerr = 1; rd_wait = 0;
      run_cmd(8'd5, 8'd9, lat, p, e, to);
      total++; if (to || p !== 16'd0 || e !== 1'b1) begin bad++; $display("FAIL ackerr_rsp got=%0d/%b want=0/1", p, e); end
      cycle();
      rd_ackerr = 0;
      // one cycle too late: RD times out
      rd_wait = 16;
      run_cmd(8'd2, 8'd3, lat, p, e, to);
      total++; if (to || p !== 16'd0 || e !== 1'b1) begin bad++; $display("FAIL rdto_rsp got=%0d/%b want=0/1", p, e); end
      total++; if (lat !== 18) begin bad++; $display("FAIL rdto_latency got=%0d want=18", lat); end
      cycle();
      rd_wait = 0;
   endtask

   task automatic test_wait_states();
      int lat; logic [15:0] p; logic e; bit to; int cr0, sb0;
      wr_wait = 3; rd_wait = 3;
      cr0 = cyc_rise; sb0 = stab_bad;
      run_cmd(8'hFF, 8'hFF, lat, p, e, to);
      total++; if (to || p !== 16'hFE01 || e !== 1'b0) begin bad++; $display("FAIL ws_rsp got=%h/%b want=fe01/0", p, e); end
      total++; if (lat !== 9) begin bad++; $display("FAIL ws_latency got=%0d want=9", lat); end
      total++; if (cyc_rise - cr0 !== 1) begin bad++; $display("FAIL ws_cyc_rises got=%0d want=1", cyc_rise - cr0); end
      total++; if (stab_bad - sb0 !== 0) begin bad++; $display("FAIL ws_stable got=%0d want=0", stab_bad - sb0); end
      total++; if (cyc !== 1'b0) begin bad++; $display("FAIL ws_cyc_in_rsp got=%b want=0", cyc); end
      cycle();
      wr_wait = 0; rd_wait = 0;
   endtask

   task automatic test_wr_timeout();
      int lat; logic [15:0] p; logic e; bit to; int rs0;
      wr_never = 1;
      rs0 = rd_stb_n;
      run_cmd(8'd5, 8'd5, lat, p, e, to);
      total++; if (to || p !== 16'd0 || e !== 1'b1) begin bad++; $display("FAIL wrto_rsp got=%0d/%b want=0/1", p, e); end
      total++; if (lat !== 17) begin bad++; $display("FAIL wrto_latency got=%0d want=17", lat); end
      total++; if (rd_stb_n - rs0 !== 0) begin bad++; $display("FAIL wrto_no_read got=%0d want=0", rd_stb_n - rs0); end
      cycle();
      wr_never = 0;
   endtask

   task automatic test_back_to_back_stall();
      int lat; logic [15:0] p; logic e; bit to; int n;
      rsp_ready = 1'b0;
      run_cmd(8'd7, 8'd6, lat, p, e, to);
      total++; if (to || lat !== 3 || p !== 16'd42) begin bad++; $display("FAIL stall_first got=%0d@%0d want=42@3", p, lat); end
      cmd_valid = 1'b1; cmd_a = 8'd1; cmd_b = 8'd1;
      for (int i = 0; i < 5; i++) begin
         cycle();
         total++; if ({rsp_valid, rsp_err, cmd_ready, cyc} !== 4'b1000 || rsp_p !== 16'd42) begin bad++; $display("FAIL stall_hold%0d got=%b/%0d want=1000/42", i, {rsp_valid, rsp_err, cmd_ready, cyc}, rsp_p); end
      end
      rsp_ready = 1'b1;
      cycle();
      total++; if ({rsp_valid, cyc, cmd_ready} !== 3'b001) begin bad++; $display("FAIL stall_release got=%b want=001", {rsp_valid, cyc, cmd_ready}); end
      cycle();
      cmd_valid = 1'b0;
      total++; if ({cyc, we} !== 2'b11 || dat_o !== 32'h0000_0101) begin bad++; $display("FAIL stall_second_wr got=%b/%h want=11/00000101", {cyc, we}, dat_o); end
      n = 0;
      while (!rsp_valid && n < 50) begin cycle(); n++; end
      total++; if (!rsp_valid || rsp_p !== 16'd1 || rsp_err !== 1'b0) begin bad++; $display("FAIL stall_second_rsp got=%b/%0d want=1/1", rsp_valid, rsp_p); end
      cycle();
   endtask

   task automatic test_reset_mid();
      int lat; logic [15:0] p; logic e; bit to; int n, seen;
      rd_wait = 5;
      cmd_valid = 1'b1; cmd_a = 8'd9; cmd_b = 8'd9;
      cycle();
      cmd_valid = 1'b0;
      n = 0;
      while (!(cyc && !we) && n < 20) begin cycle(); n++; end
      total++; if ({cyc, we} !== 2'b10) begin bad++; $display("FAIL rmid_reach_rd got=%b want=10", {cyc, we}); end
      cycle();
      rst = 1'b1;
      cycle();
      total++; if ({cyc, stb, rsp_valid, cmd_ready} !== 4'b0000) begin bad++; $display("FAIL rmid_drop got=%b want=0000", {cyc, stb, rsp_valid, cmd_ready}); end
      rst = 1'b0;
      rd_wait = 0;
      cycle();
      total++; if (cmd_ready !== 1'b1) begin bad++; $display("FAIL rmid_ready got=%b want=1", cmd_ready); end
      seen = 0;
      for (int i = 0; i < 10; i++) begin
         if (rsp_valid || cyc) seen++;
         cycle();
      end
      total++; if (seen !== 0) begin bad++; $display("FAIL rmid_ghost got=%0d want=0", seen); end
      run_cmd(8'd12, 8'd12, lat, p, e, to);
      total++; if (to || lat !== 3 || p !== 16'd144 || e !== 1'b0) begin bad++; $display("FAIL rmid_after got=%0d/%b@%0d want=144/0@3", p, e, lat); end
      cycle();
   endtask

   initial begin
      test_reset();
      test_zero_wait();
      test_rd_err();
      test_wait_states();
      test_wr_timeout();
      test_back_to_back_stall();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog expired");
      $fatal(1);
   end

endmodule
